bus_chkr_hw: RTL and testbench
==============================

# bus_chkr_hw

Synthesizable, parametrised checker for the multi-driver bus testbench. It records every packet a driver sends and, per destination, keeps an ordered queue of expected packets. Each packet the monitors observe is compared in order against its destination queue, and the checker reports match, mismatch or unexpected with the measured latency. It sits beside the bus DUT as the hardware successor of the class-based checker. It adds broadcast, bounded queue depth, latency measurement and error counters.

## Interface
- DRVRS, 4: number of bus ports/destinations (2..16).
- PCKG_SZ, 16: packet width; bits [PCKG_SZ-1:PCKG_SZ-8] are the destination ID, the rest is payload.
- DEPTH, 8: expected-queue entries per destination (power of 2, ≥2).
- TS_W, 16: timestamp/latency width.
- BCAST_ID, 8'hFF: broadcast destination ID.
- CNT_W, 16: counter width.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- exp_valid  in  1  driver-sent packet strobe.
- exp_src  in  $clog2(DRVRS)  sending port.
- exp_data  in  PCKG_SZ  sent packet.
- obs_valid  in  1  monitor-observed packet strobe.
- obs_port  in  $clog2(DRVRS)  port where the packet was observed.
- obs_data  in  PCKG_SZ  observed packet.
- rslt_valid  out  1  result strobe.
- rslt_code  out  2  00 match, 01 mismatch, 10 unexpected.
- rslt_port  out  $clog2(DRVRS)  port of the result.
- rslt_latency  out  TS_W  observe time minus send time (0 unless match/mismatch).
- match_cnt, err_cnt  out  CNT_W  saturating counters.
- ovf  out  1  sticky: a push was dropped because a queue was full.
- bad_dest  out  1  sticky: a sent packet had an ID ≥ DRVRS and ≠ BCAST_ID.
- pending  out  1  some queue is non-empty.

## Operation
- Free-running timestamp counter `ts`: 0 after reset, +1 per cycle, wraps modulo 2^TS_W.
- Each entry in a queue holds {packet, ts at push}.
- Push (exp_valid):
  - ID d < DRVRS: push into queue d.
  - ID = BCAST_ID: push the same entry into every queue except exp_src.
  - Any other ID: no push; set bad_dest.
  - Full target queue: that push is dropped and ovf is set. For broadcast, the other non-full queues still receive the entry.
- Observe (obs_valid) at port p:
  - Queue p empty: code 10, err_cnt+1, nothing popped.
  - Head packet == obs_data: code 00, pop, match_cnt+1.
  - Otherwise: code 01, pop (resynchronise), err_cnt+1.
  - Latency = (ts − head stamp) mod 2^TS_W.
- Push and observe in the same cycle on the same queue:
  - Push and pop both take effect.
  - If the queue was empty, the observe is 10. There is no same-cycle bypass.
  - If the queue was full, the pop frees space first, so the push is not dropped.
- Counters saturate at all-ones. ovf and bad_dest clear only on reset.

## Timing
- Result latency is 1 cycle: obs_valid in cycle N gives rslt_valid in N+1. rslt_* hold their last value when rslt_valid=0.
- A push in cycle N is visible to an observe in N+1.
- pending updates 1 cycle after a push/pop. Full occupancy is DEPTH entries.
- On reset_n low, asynchronously:
  - all queues empty, ts=0;
  - rslt_valid=0, rslt_code=0, rslt_port=0, rslt_latency=0;
  - match_cnt=0, err_cnt=0, ovf=0, bad_dest=0, pending=0.
- Reset mid-traffic discards all queued entries. The first cycle after release accepts new strobes.
- No backpressure: strobes are accepted every cycle.

## Test plan
- Single in-order path (DRVRS=4):
  - Push 16'h00FF, 16'h01AB, 16'h02CC, 16'h00DA at ts=5,6,7,8.
  - Observe the same packets at ts=20..23 on ports 0,1,2,0.
  - Expect four code 00 results with latency 15,15,15,15; match_cnt=4, pending=0.
- Mismatch:
  - Push 16'h01AB, then observe 16'h01AC on port 1.
  - Expect code 01, err_cnt=1, queue 1 empty.
- Broadcast:
  - exp_src=2, push 16'hFF55.
  - Observe 16'hFF55 on ports 0, 1, 3: three 00 results.
  - Observe on port 2: code 10.
- Overflow with DEPTH=8:
  - Push 9 packets to destination 3: ovf=1.
  - 8 observes match; a 9th observe gives 10.
- Full-queue pop+push:
  - Fill queue 0, then in one cycle observe the head and push 16'h0077.
  - Expect no ovf; 16'h0077 is matched last.
- Bad destination and reset:
  - Push 16'h0511: bad_dest=1, pending=0.
  - Assert reset_n mid-traffic: all outputs 0, queues empty.

Source files
------------

// File: rtl/bus_chkr_hw.sv
// Scoreboard checker for the multi-driver bus. It keeps one ordered queue of expected
// packets per destination and grades each observed packet against that queue.
module bus_chkr_hw #(
  parameter int unsigned DRVRS    = 4,
  parameter int unsigned PCKG_SZ  = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_W     = 16,
  parameter logic [7:0]  BCAST_ID = 8'hFF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       exp_valid,
  input  logic [$clog2(DRVRS)-1:0]   exp_src,
  input  logic [PCKG_SZ-1:0]         exp_data,
  input  logic                       obs_valid,
  input  logic [$clog2(DRVRS)-1:0]   obs_port,
  input  logic [PCKG_SZ-1:0]         obs_data,
  output logic                       rslt_valid,
  output logic [1:0]                 rslt_code,
  output logic [$clog2(DRVRS)-1:0]   rslt_port,
  output logic [TS_W-1:0]            rslt_latency,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic                       ovf,
  output logic                       bad_dest,
  output logic                       pending
);

  localparam int unsigned PW = $clog2(DRVRS);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = PCKG_SZ + TS_W;

  typedef enum logic [1:0] {
    RES_MATCH    = 2'b00,
    RES_MISMATCH = 2'b01,
    RES_UNEXP    = 2'b10
  } res_e;

  logic [EW-1:0]      mem    [DRVRS][DEPTH];
  logic [AW-1:0]      wr_ptr [DRVRS];
  logic [AW-1:0]      rd_ptr [DRVRS];
  logic [AW:0]        cnt    [DRVRS];
  logic [AW:0]        cnt_nxt[DRVRS];
  logic [DRVRS-1:0]   push_req;
  logic [DRVRS-1:0]   push_ok;
  logic [DRVRS-1:0]   pop;
  logic [DRVRS-1:0]   nonempty_nxt;
  logic [TS_W-1:0]    ts;
  logic [7:0]         id;
  logic               dest_ok;
  logic               is_bcast;
  logic               port_ok;
  logic               occ;
  logic [EW-1:0]      head;
  logic [PCKG_SZ-1:0] head_pkt;
  logic [TS_W-1:0]    head_ts;

  assign id = exp_data[PCKG_SZ-1 -: 8];

  always_comb begin
    dest_ok  = id < 8'(DRVRS);
    is_bcast = (id == BCAST_ID);
    port_ok  = {1'b0, obs_port} < (PW+1)'(DRVRS);
    head     = port_ok ? mem[obs_port][rd_ptr[obs_port]] : '0;
    occ      = port_ok && (cnt[obs_port] != '0);
    head_pkt = head[EW-1:TS_W];
    head_ts  = head[TS_W-1:0];
    for (int unsigned q = 0; q < DRVRS; q++) begin
      push_req[q] = exp_valid &&
                    ((dest_ok && id == 8'(q)) ||
                     (!dest_ok && is_bcast && exp_src != PW'(q)));
      pop[q]      = obs_valid && (obs_port == PW'(q)) && (cnt[q] != '0);
      // A same-cycle pop frees the slot, so a full queue still accepts the push.
      push_ok[q]  = push_req[q] && ((cnt[q] != (AW+1)'(DEPTH)) || pop[q]);
      cnt_nxt[q]  = cnt[q] + (AW+1)'(push_ok[q]) - (AW+1)'(pop[q]);
      nonempty_nxt[q] = (cnt_nxt[q] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned q = 0; q < DRVRS; q++) begin
      if (push_ok[q]) mem[q][wr_ptr[q]] <= {exp_data, ts};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts           <= '0;
      for (int unsigned q = 0; q < DRVRS; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
      rslt_valid   <= 1'b0;
      rslt_code    <= '0;
      rslt_port    <= '0;
      rslt_latency <= '0;
      match_cnt    <= '0;
      err_cnt      <= '0;
      ovf          <= 1'b0;
      bad_dest     <= 1'b0;
      pending      <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      for (int unsigned q = 0; q < DRVRS; q++) begin
        if (push_ok[q]) wr_ptr[q] <= wr_ptr[q] + AW'(1);
        if (pop[q])     rd_ptr[q] <= rd_ptr[q] + AW'(1);
        cnt[q] <= cnt_nxt[q];
      end
      pending <= |nonempty_nxt;
      if (|(push_req & ~push_ok))                 ovf      <= 1'b1;
      if (exp_valid && !dest_ok && !is_bcast)     bad_dest <= 1'b1;

      rslt_valid <= obs_valid;
      if (obs_valid) begin
        rslt_port <= obs_port;
        if (!occ) begin
          rslt_code    <= RES_UNEXP;
          rslt_latency <= '0;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end else begin
          rslt_latency <= ts - head_ts;
          if (head_pkt == obs_data) begin
            rslt_code <= RES_MATCH;
            if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
          end else begin
            rslt_code <= RES_MISMATCH;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_chkr_hw.sv
// Directed bench for bus_chkr_hw: observations queue their expected result, and a
// separate monitor grades every rslt_valid pulse against that queue.
module tb_bus_chkr_hw;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exp_valid;
  logic [1:0]  exp_src;
  logic [15:0] exp_data;
  logic        obs_valid;
  logic [1:0]  obs_port;
  logic [15:0] obs_data;
  logic        rslt_valid;
  logic [1:0]  rslt_code;
  logic [1:0]  rslt_port;
  logic [15:0] rslt_latency;
  logic [15:0] match_cnt;
  logic [15:0] err_cnt;
  logic        ovf;
  logic        bad_dest;
  logic        pending;

  bus_chkr_hw #(
    .DRVRS(4), .PCKG_SZ(16), .DEPTH(8), .TS_W(16), .BCAST_ID(8'hFF), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .exp_valid(exp_valid), .exp_src(exp_src), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_port(obs_port), .obs_data(obs_data),
    .rslt_valid(rslt_valid), .rslt_code(rslt_code), .rslt_port(rslt_port),
    .rslt_latency(rslt_latency), .match_cnt(match_cnt), .err_cnt(err_cnt),
    .ovf(ovf), .bad_dest(bad_dest), .pending(pending)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    logic [1:0]  port;
    logic [15:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          exp_match = 0;
  int          exp_err = 0;
  logic [15:0] tb_ts;

  // Reference timestamp, kept independently of the DUT.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    obs_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] src);
    exp_valid = 1'b1;
    exp_data  = d;
    exp_src   = src;
  endtask

  task automatic obs(input logic [15:0] d, input logic [1:0] p,
                     input logic [1:0] code, input logic [15:0] lat);
    exp_t e;
    obs_valid = 1'b1;
    obs_data  = d;
    obs_port  = p;
    e.code = code;
    e.port = p;
    e.lat  = lat;
    sb.push_back(e);
    if (code == 2'b00) exp_match++;
    else               exp_err++;
  endtask

  task automatic wait_ts(input logic [15:0] t);
    int n = 0;
    while (tb_ts != t && n < 1000) begin
      tick();
      n++;
    end
    chk("wait_ts_bound", 32'(tb_ts), 32'(t));
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(exp_match));
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'(exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rslt_valid"},   32'(rslt_valid),   0);
    chk({tag, "_rslt_code"},    32'(rslt_code),    0);
    chk({tag, "_rslt_port"},    32'(rslt_port),    0);
    chk({tag, "_rslt_latency"}, 32'(rslt_latency), 0);
    chk({tag, "_match_cnt"},    32'(match_cnt),    0);
    chk({tag, "_err_cnt"},      32'(err_cnt),      0);
    chk({tag, "_ovf"},          32'(ovf),          0);
    chk({tag, "_bad_dest"},     32'(bad_dest),     0);
    chk({tag, "_pending"},      32'(pending),      0);
  endtask

  // Monitor: grades each result pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rslt_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rslt", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rslt_code",    32'(rslt_code),    32'(e.code));
          chk("rslt_port",    32'(rslt_port),    32'(e.port));
          chk("rslt_latency", 32'(rslt_latency), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pts, pts2;
    logic [15:0] fts [8];
    reset_n   = 1'b0;
    exp_valid = 1'b0;
    exp_src   = '0;
    exp_data  = '0;
    obs_valid = 1'b0;
    obs_port  = '0;
    obs_data  = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // In-order path: pushes at ts 5..8, observes at ts 20..23.
    wait_ts(16'd5);
    push(16'h00FF, 2'd0); tick();
    push(16'h01AB, 2'd0); tick();
    push(16'h02CC, 2'd0); tick();
    push(16'h00DA, 2'd0); tick();
    chk("inorder_pending_before", 32'(pending), 1);
    wait_ts(16'd20);
    obs(16'h00FF, 2'd0, 2'b00, 16'd15); tick();
    obs(16'h01AB, 2'd1, 2'b00, 16'd15); tick();
    obs(16'h02CC, 2'd2, 2'b00, 16'd15); tick();
    obs(16'h00DA, 2'd0, 2'b00, 16'd15); tick();
    chk("inorder_match_cnt", 32'(match_cnt), 4);
    chk("inorder_pending",   32'(pending),   0);

    // Mismatch pops the head; a second observe then finds the queue empty.
    pts = tb_ts;
    push(16'h01AB, 2'd3); tick();
    obs(16'h01AC, 2'd1, 2'b01, tb_ts - pts); tick();
    chk("mismatch_err_cnt", 32'(err_cnt), 1);
    chk("mismatch_pending", 32'(pending), 0);
    obs(16'h01AB, 2'd1, 2'b10, 16'd0); tick();
    chk_cnts("mismatch");

    // Broadcast from port 2 reaches every queue except 2.
    pts = tb_ts;
    push(16'hFF55, 2'd2); tick();
    tick();
    obs(16'hFF55, 2'd0, 2'b00, tb_ts - pts); tick();
    obs(16'hFF55, 2'd1, 2'b00, tb_ts - pts); tick();
    obs(16'hFF55, 2'd3, 2'b00, tb_ts - pts); tick();
    obs(16'hFF55, 2'd2, 2'b10, 16'd0); tick();
    chk_cnts("bcast");
    chk("bcast_pending", 32'(pending), 0);

    // Full queue 0: pop of the head and a push in the same cycle.
    for (int i = 0; i < 8; i++) begin
      fts[i] = tb_ts;
      push(16'h0010 + 16'(i), 2'd1); tick();
    end
    chk("full_ovf_before", 32'(ovf), 0);
    pts = tb_ts;
    push(16'h0077, 2'd1);
    obs(16'h0010, 2'd0, 2'b00, tb_ts - fts[0]); tick();
    chk("full_popush_ovf", 32'(ovf), 0);
    for (int i = 1; i < 8; i++) begin
      obs(16'h0010 + 16'(i), 2'd0, 2'b00, tb_ts - fts[i]); tick();
    end
    chk("full_pending_last", 32'(pending), 1);
    obs(16'h0077, 2'd0, 2'b00, tb_ts - pts); tick();
    chk("full_pending_empty", 32'(pending), 0);
    chk_cnts("full");

    // Overflow: the ninth push to destination 3 is dropped.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) fts[i] = tb_ts;
      push(16'h0300 + 16'(i), 2'd0); tick();
      if (i == 7) chk("ovf_after8", 32'(ovf), 0);
    end
    chk("ovf_after9", 32'(ovf), 1);
    for (int i = 0; i < 8; i++) begin
      obs(16'h0300 + 16'(i), 2'd3, 2'b00, tb_ts - fts[i]); tick();
    end
    obs(16'h0308, 2'd3, 2'b10, 16'd0); tick();
    chk_cnts("ovf");

    // Bad destination ID.
    push(16'h0511, 2'd0); tick();
    chk("bad_dest_flag",    32'(bad_dest), 1);
    chk("bad_dest_pending", 32'(pending),  0);

    // Reset in the middle of traffic.
    push(16'h0100, 2'd0); tick();
    push(16'h0200, 2'd0); tick();
    chk("pre_reset_pending", 32'(pending), 1);
    obs_valid = 1'b1;
    obs_data  = 16'h0100;
    obs_port  = 2'd1;
    #2;
    reset_n   = 1'b0;
    obs_valid = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_match = 0;
    exp_err   = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs(16'h0100, 2'd1, 2'b10, 16'd0); tick();
    pts = tb_ts;
    push(16'h0142, 2'd0); tick();
    pts2 = tb_ts;
    obs(16'h0142, 2'd1, 2'b00, pts2 - pts); tick();
    chk_cnts("post_reset");
    chk("post_reset_pending", 32'(pending), 0);

    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
